// File: rtl/arb_playback_reader.sv
// Arbitrary-waveform playback reader: streams 64-bit DDR words into a FIFO
// and unpacks them into 16-bit DAC samples with a sync window marker.
//
// Ports:
//   CLK_DDS_IN            sole clock (rising edge)
//   RESET_N               asynchronous active-low reset
//   DAC0_ACT              playback enable
//   ARB_SIZE[31:0]        waveform length in samples ([23:2] used)
//   SYNC_START/SYNC_END   sync window bounds in sample index ([23:0] used)
//   RD_REQ, RD_ADDR[25:0] DDR read request / address
//   RD_ACK                request accepted (one cycle)
//   RD_VALID, RD_DATA     returned word strobe / data
//   SAMPLE_OUT[15:0]      registered sample, SAMPLE_VALID qualifier
//   SYNC_OUT              sync marker aligned with SAMPLE_OUT
//   UNDERRUN              sticky starvation flag
module arb_playback_reader #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK_DDS_IN,
    input  logic        RESET_N,
    input  logic        DAC0_ACT,
    input  logic [31:0] ARB_SIZE,
    input  logic [31:0] SYNC_START,
    input  logic [31:0] SYNC_END,
    output logic        RD_REQ,
    output logic [25:0] RD_ADDR,
    input  logic        RD_ACK,
    input  logic        RD_VALID,
    input  logic [63:0] RD_DATA,
    output logic [15:0] SAMPLE_OUT,
    output logic        SAMPLE_VALID,
    output logic        SYNC_OUT,
    output logic        UNDERRUN
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nx;
    logic [21:0]   r_words;
    logic [23:0]   r_ss;
    logic [23:0]   r_se;
    logic [21:0]   r_w;
    logic [23:0]   r_s;
    logic [1:0]    r_lane;
    logic          r_req;
    logic          r_out;
    logic [63:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic [15:0]   r_sample;
    logic          r_valid;
    logic          r_sync;
    logic          r_under;

    logic          w_start;
    logic          w_active;
    logic          w_ack;
    logic          w_ret;
    logic          w_push;
    logic          w_emit_ok;
    logic          w_stall;
    logic          w_emit;
    logic          w_pop;
    logic          w_flush;
    logic          w_latch;
    logic          w_w_last;
    logic          w_s_last;
    logic          w_sync;
    logic          w_req_ok;
    logic [63:0]   w_word;
    logic [15:0]   w_lane_data;

    wire w_unused = &{1'b0, ARB_SIZE[31:24], ARB_SIZE[1:0],
                      SYNC_START[31:24], SYNC_END[31:24]};

    assign w_start   = DAC0_ACT && (ARB_SIZE[23:2] != 22'd0);
    assign w_latch   = (r_state == S_IDLE) && w_start;
    assign w_active  = (r_state == S_FILL) || (r_state == S_RUN);
    assign w_ack     = r_req && RD_ACK;
    // A strobe with nothing in flight (e.g. after reset) is dropped here.
    assign w_ret     = RD_VALID && r_out;
    assign w_push    = w_ret && w_active;
    assign w_emit_ok = (r_state == S_RUN) && DAC0_ACT;
    assign w_stall   = w_emit_ok && (r_lane == 2'd0) && (r_cnt == '0);
    assign w_emit    = w_emit_ok && !w_stall;
    assign w_pop     = w_emit && (r_lane == 2'd3);
    assign w_flush   = (r_state == S_DRAIN) && (!r_out || RD_VALID);
    assign w_w_last  = (r_w == (r_words - 22'd1));
    assign w_s_last  = (r_s == ({r_words, 2'b00} - 24'd1));
    assign w_sync    = (r_ss < r_se) && (r_s >= r_ss) && (r_s < r_se);
    assign w_req_ok  = w_active && DAC0_ACT;

    assign w_word      = r_mem[r_rp];
    assign w_lane_data = w_word[{r_lane, 4'b0000} +: 16];

    // Address packing mirrors the host write path layout.
    assign RD_ADDR = {r_w[20:8], 1'b0, r_w[7:0], 2'b00, 1'b0, r_w[21]};
    assign RD_REQ       = r_req;
    assign SAMPLE_OUT   = r_sample;
    assign SAMPLE_VALID = r_valid;
    assign SYNC_OUT     = r_sync;
    assign UNDERRUN     = r_under;

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start) w_state_nx = S_FILL;
            end
            S_FILL: begin
                if (!DAC0_ACT)             w_state_nx = S_DRAIN;
                else if (r_cnt == DEPTH_C) w_state_nx = S_RUN;
            end
            S_RUN: begin
                if (!DAC0_ACT) w_state_nx = S_DRAIN;
            end
            default: begin
                if (w_flush) w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_DDS_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Configuration and indices restart only on IDLE->FILL.
    always_ff @(posedge CLK_DDS_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            r_words <= '0;
            r_ss    <= '0;
            r_se    <= '0;
            r_w     <= '0;
            r_s     <= '0;
            r_lane  <= '0;
            r_under <= 1'b0;
        end else if (w_latch) begin
            r_words <= ARB_SIZE[23:2];
            r_ss    <= SYNC_START[23:0];
            r_se    <= SYNC_END[23:0];
            r_w     <= '0;
            r_s     <= '0;
            r_lane  <= '0;
            r_under <= 1'b0;
        end else begin
            if (w_ack) begin
                r_w <= w_w_last ? 22'd0 : r_w + 22'd1;
            end
            if (w_emit) begin
                r_lane <= r_lane + 2'd1;
                r_s    <= w_s_last ? 24'd0 : r_s + 24'd1;
            end
            if (w_stall) begin
                r_under <= 1'b1;
            end
        end
    end

    // Single outstanding read; the request is held until accepted.
    always_ff @(posedge CLK_DDS_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            r_req <= 1'b0;
            r_out <= 1'b0;
        end else begin
            if (w_ack) begin
                r_req <= 1'b0;
            end else if (!w_req_ok) begin
                r_req <= 1'b0;
            end else if (!r_req && !r_out && (r_cnt < DEPTH_C)) begin
                r_req <= 1'b1;
            end
            if (w_ack) begin
                r_out <= 1'b1;
            end else if (w_ret) begin
                r_out <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK_DDS_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= RD_DATA;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge CLK_DDS_IN or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sample <= '0;
            r_valid  <= 1'b0;
            r_sync   <= 1'b0;
        end else begin
            r_valid <= w_emit;
            r_sync  <= w_emit && w_sync;
            if (w_emit) begin
                r_sample <= w_lane_data;
            end
        end
    end

endmodule

// File: tb/tb_arb_playback_reader.sv
// Directed bench for arb_playback_reader with a one-read DDR responder.
module tb_arb_playback_reader;

    logic        clk = 1'b0;
    logic        RESET_N;
    logic        DAC0_ACT;
    logic [31:0] ARB_SIZE;
    logic [31:0] SYNC_START;
    logic [31:0] SYNC_END;
    logic        RD_REQ;
    logic [25:0] RD_ADDR;
    logic        RD_ACK;
    logic        RD_VALID;
    logic [63:0] RD_DATA;
    logic [15:0] SAMPLE_OUT;
    logic        SAMPLE_VALID;
    logic        SYNC_OUT;
    logic        UNDERRUN;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    int exp_s;
    int exp_size;
    int ss;
    int se;
    int gaps;
    int ack_base;

    logic hold_valid = 1'b0;
    logic resp_rst = 1'b0;
    int   stray_req = 0;
    logic pending;
    int   nacks;
    logic [25:0] addr_log [0:2047];

    arb_playback_reader #(.FIFO_DEPTH(4)) dut (
        .CLK_DDS_IN(clk),
        .RESET_N(RESET_N),
        .DAC0_ACT(DAC0_ACT),
        .ARB_SIZE(ARB_SIZE),
        .SYNC_START(SYNC_START),
        .SYNC_END(SYNC_END),
        .RD_REQ(RD_REQ),
        .RD_ADDR(RD_ADDR),
        .RD_ACK(RD_ACK),
        .RD_VALID(RD_VALID),
        .RD_DATA(RD_DATA),
        .SAMPLE_OUT(SAMPLE_OUT),
        .SAMPLE_VALID(SAMPLE_VALID),
        .SYNC_OUT(SYNC_OUT),
        .UNDERRUN(UNDERRUN)
    );

    initial forever #5 clk = ~clk;

    // Memory word w holds samples 4w+1 .. 4w+4 in lanes 0..3.
    function automatic logic [63:0] word_of(input logic [25:0] a);
        logic [21:0] wi;
        int b;
        wi = {a[0], a[25:13], a[11:4]};
        b = 4 * int'(wi);
        return {16'(b + 4), 16'(b + 3), 16'(b + 2), 16'(b + 1)};
    endfunction

    initial begin : resp
        int phase;
        int stray_done;
        logic [25:0] aq;
        phase = 0;
        stray_done = 0;
        aq = '0;
        nacks = 0;
        pending = 1'b0;
        RD_ACK = 1'b0;
        RD_VALID = 1'b0;
        RD_DATA = '0;
        forever begin
            @(negedge clk);
            if (resp_rst) begin
                RD_ACK = 1'b0;
                RD_VALID = 1'b0;
                phase = 0;
                pending = 1'b0;
            end else if (phase == 0) begin
                RD_VALID = 1'b0;
                if (stray_req != stray_done) begin
                    stray_done = stray_req;
                    RD_VALID = 1'b1;
                    RD_DATA = 64'hDEAD_BEEF_CAFE_F00D;
                    phase = 2;
                end else if (RD_REQ) begin
                    RD_ACK = 1'b1;
                    aq = RD_ADDR;
                    if (nacks < 2048) addr_log[nacks] = aq;
                    nacks++;
                    phase = 1;
                end
            end else if (phase == 1) begin
                RD_ACK = 1'b0;
                if (hold_valid) begin
                    pending = 1'b1;
                end else begin
                    pending = 1'b0;
                    RD_VALID = 1'b1;
                    RD_DATA = word_of(aq);
                    phase = 2;
                end
            end else begin
                RD_VALID = 1'b0;
                phase = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic check_sample();
        logic sy;
        sy = (ss < se) && (exp_s >= ss) && (exp_s < se);
        chk("sample", 32'(SAMPLE_OUT), 32'(exp_s + 1));
        chk("sync", 32'(SYNC_OUT), 32'(sy));
        exp_s = (exp_s + 1) % exp_size;
    endtask

    task automatic wait_valid(input int maxcyc);
        int c;
        c = 0;
        while (!SAMPLE_VALID && c < maxcyc) begin
            @(negedge clk);
            c++;
        end
        chk("wait_valid", 32'(SAMPLE_VALID), 32'd1);
    endtask

    task automatic run(input int nsamp, input int maxcyc);
        int got;
        int c;
        got = 0;
        c = 0;
        while (got < nsamp && c < maxcyc) begin
            if (SAMPLE_VALID) begin
                check_sample();
                got++;
            end else begin
                gaps++;
            end
            @(negedge clk);
            c++;
        end
        chk("run_done", 32'(got), 32'(nsamp));
    endtask

    task automatic run_cyc(input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            if (SAMPLE_VALID) check_sample();
            else gaps++;
            @(negedge clk);
        end
    endtask

    initial begin : main
        int c;
        RESET_N = 1'b0;
        DAC0_ACT = 1'b0;
        ARB_SIZE = '0;
        SYNC_START = '0;
        SYNC_END = '0;
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(RD_REQ), 0);
        chk("rst_addr", 32'(RD_ADDR), 0);
        chk("rst_sample", 32'(SAMPLE_OUT), 0);
        chk("rst_valid", 32'(SAMPLE_VALID), 0);
        chk("rst_sync", 32'(SYNC_OUT), 0);
        chk("rst_under", 32'(UNDERRUN), 0);
        RESET_N = 1'b1;
        @(negedge clk);

        // Size below one word must not start playback.
        ARB_SIZE = 32'd3;
        DAC0_ACT = 1'b1;
        repeat (10) @(negedge clk);
        chk("tiny_no_req", 32'(RD_REQ), 0);

        // Basic playback, 8 samples, sync window 2..4.
        ack_base = nacks;
        SYNC_START = 32'd2;
        SYNC_END = 32'd5;
        ss = 2; se = 5; exp_s = 0; exp_size = 8;
        ARB_SIZE = 32'd8;
        wait_valid(100);
        gaps = 0;
        run(24, 100);
        chk("steady_gaps", 32'(gaps), 0);
        chk("steady_under", 32'(UNDERRUN), 0);
        chk("addr0", 32'(addr_log[ack_base]), 32'h0);
        chk("addr1", 32'(addr_log[ack_base + 1]), 32'h10);
        chk("addr2", 32'(addr_log[ack_base + 2]), 32'h0);
        chk("addr3", 32'(addr_log[ack_base + 3]), 32'h10);

        // Starvation: hold returns long enough to drain the FIFO.
        hold_valid = 1'b1;
        gaps = 0;
        run_cyc(40);
        chk("gap_seen", 32'(gaps > 0), 1);
        chk("under_set", 32'(UNDERRUN), 1);
        hold_valid = 1'b0;
        run(24, 300);
        chk("under_sticky", 32'(UNDERRUN), 1);

        // Disable with a read in flight; re-enable while still draining.
        hold_valid = 1'b1;
        c = 0;
        while (!pending && c < 50) begin
            @(negedge clk);
            c++;
        end
        chk("pending", 32'(pending), 1);
        DAC0_ACT = 1'b0;
        repeat (3) @(negedge clk);
        chk("drain_req", 32'(RD_REQ), 0);
        chk("drain_valid", 32'(SAMPLE_VALID), 0);
        chk("drain_sync", 32'(SYNC_OUT), 0);
        ARB_SIZE = 32'hFF00_000B;
        SYNC_START = 32'd5;
        SYNC_END = 32'd2;
        DAC0_ACT = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("drain_hold", 32'(RD_REQ), 0);
        end
        chk("under_kept", 32'(UNDERRUN), 1);
        ack_base = nacks;
        ss = 5; se = 2; exp_s = 0; exp_size = 8;
        hold_valid = 1'b0;
        wait_valid(100);
        chk("under_clr", 32'(UNDERRUN), 0);
        run(16, 200);
        chk("restart_a0", 32'(addr_log[ack_base]), 32'h0);
        chk("restart_a1", 32'(addr_log[ack_base + 1]), 32'h10);

        // Long waveform to cross the w[7:0] -> w[20:8] address boundary.
        DAC0_ACT = 1'b0;
        repeat (8) @(negedge clk);
        ack_base = nacks;
        ARB_SIZE = 32'd2051;
        SYNC_START = '0;
        SYNC_END = '0;
        ss = 0; se = 0; exp_s = 0; exp_size = 2048;
        DAC0_ACT = 1'b1;
        wait_valid(100);
        run(1040, 1300);
        chk("addr_255", 32'(addr_log[ack_base + 255]), 32'hFF0);
        chk("addr_256", 32'(addr_log[ack_base + 256]), 32'h2000);
        chk("addr_257", 32'(addr_log[ack_base + 257]), 32'h2010);

        // Asynchronous reset mid-run, then a stray return strobe.
        chk("pre_rst_nz", 32'(SAMPLE_OUT != 16'd0), 1);
        resp_rst = 1'b1;
        #2;
        RESET_N = 1'b0;
        #1;
        chk("arst_req", 32'(RD_REQ), 0);
        chk("arst_addr", 32'(RD_ADDR), 0);
        chk("arst_sample", 32'(SAMPLE_OUT), 0);
        chk("arst_valid", 32'(SAMPLE_VALID), 0);
        chk("arst_sync", 32'(SYNC_OUT), 0);
        chk("arst_under", 32'(UNDERRUN), 0);
        DAC0_ACT = 1'b0;
        repeat (2) @(negedge clk);
        RESET_N = 1'b1;
        resp_rst = 1'b0;
        stray_req++;
        repeat (4) @(negedge clk);
        ack_base = nacks;
        ARB_SIZE = 32'd8;
        SYNC_START = 32'd2;
        SYNC_END = 32'd5;
        ss = 2; se = 5; exp_s = 0; exp_size = 8;
        DAC0_ACT = 1'b1;
        wait_valid(100);
        run(12, 100);
        chk("post_rst_a0", 32'(addr_log[ack_base]), 32'h0);
        chk("post_rst_under", 32'(UNDERRUN), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
